// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk_i down to SCLK, serialises one stereo pair per 64-slot frame
// from a single-entry holding register, and sends a mute frame with an underrun pulse if the holder is empty.
module i2s_tx #(
  parameter int unsigned WIDTH_P    = 24,
  parameter int unsigned SCLK_DIV_P = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [WIDTH_P-1:0] left_i,
  input  logic [WIDTH_P-1:0] right_i,
  output logic               ready_o,
  output logic               sclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underrun_o
);

  localparam int unsigned DIV_W = (SCLK_DIV_P > 1) ? $clog2(SCLK_DIV_P) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_DIV_P - 1);
  localparam logic [5:0] LEFT_HI  = 6'(WIDTH_P);
  localparam logic [5:0] RIGHT_LO = 6'd33;
  localparam logic [5:0] RIGHT_HI = 6'(32 + WIDTH_P);
  localparam logic [5:0] LAST_SLOT = 6'd63;

  logic [DIV_W-1:0]   div, div_d;
  logic               sclk, sclk_d;
  logic [5:0]         slot, slot_d;
  logic               lrclk, lrclk_d;
  logic               sdata, sdata_d;
  logic               underrun, underrun_d;
  logic               ready, ready_d;
  logic               hold_valid, hold_valid_d;
  logic [WIDTH_P-1:0] hold_l, hold_l_d;
  logic [WIDTH_P-1:0] hold_r, hold_r_d;
  logic [WIDTH_P-1:0] act_l, act_l_d;
  logic [WIDTH_P-1:0] act_r, act_r_d;

  logic               div_tc;
  logic               fall;
  logic               boundary;
  logic               accept;
  logic [5:0]         slot_nx;
  logic [5:0]         shamt;
  logic [WIDTH_P-1:0] mask;
  logic               ser_bit;

  assign div_tc   = (div == DIV_MAX);
  assign fall     = div_tc && sclk;
  assign boundary = fall && (slot == LAST_SLOT);
  assign accept   = valid_i && ready;
  assign slot_nx  = slot + 6'd1;

  // Data bit for the slot being entered; the one-slot I2S delay puts the MSB in slot 1 / 33.
  always_comb begin
    shamt   = 6'd0;
    mask    = '0;
    ser_bit = 1'b0;
    if ((slot_nx >= 6'd1) && (slot_nx <= LEFT_HI)) begin
      shamt   = LEFT_HI - slot_nx;
      mask    = WIDTH_P'(1) << shamt;
      ser_bit = |(act_l & mask);
    end else if ((slot_nx >= RIGHT_LO) && (slot_nx <= RIGHT_HI)) begin
      shamt   = RIGHT_HI - slot_nx;
      mask    = WIDTH_P'(1) << shamt;
      ser_bit = |(act_r & mask);
    end
  end

  // Next-state for divider, frame timing and the holder/active register pair.
  always_comb begin
    div_d        = div;
    sclk_d       = sclk;
    slot_d       = slot;
    lrclk_d      = lrclk;
    sdata_d      = sdata;
    underrun_d   = 1'b0;
    hold_valid_d = hold_valid;
    hold_l_d     = hold_l;
    hold_r_d     = hold_r;
    act_l_d      = act_l;
    act_r_d      = act_r;

    div_d = div_tc ? '0 : div + DIV_W'(1);
    if (div_tc) begin
      sclk_d = ~sclk;
    end

    if (accept) begin
      hold_l_d     = left_i;
      hold_r_d     = right_i;
      hold_valid_d = 1'b1;
    end

    // A pair captured on the boundary edge itself is not seen until the next frame.
    if (boundary) begin
      if (hold_valid) begin
        act_l_d      = hold_l;
        act_r_d      = hold_r;
        hold_valid_d = 1'b0;
      end else begin
        act_l_d    = '0;
        act_r_d    = '0;
        underrun_d = 1'b1;
      end
    end

    if (fall) begin
      slot_d  = slot_nx;
      lrclk_d = slot_nx[5];
      sdata_d = ser_bit;
    end

    ready_d = ~hold_valid_d;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      div        <= '0;
      sclk       <= 1'b0;
      slot       <= LAST_SLOT;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      ready      <= 1'b1;
      hold_valid <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      act_l      <= '0;
      act_r      <= '0;
    end else begin
      div        <= div_d;
      sclk       <= sclk_d;
      slot       <= slot_d;
      lrclk      <= lrclk_d;
      sdata      <= sdata_d;
      underrun   <= underrun_d;
      ready      <= ready_d;
      hold_valid <= hold_valid_d;
      hold_l     <= hold_l_d;
      hold_r     <= hold_r_d;
      act_l      <= act_l_d;
      act_r      <= act_r_d;
    end
  end

  assign ready_o    = ready;
  assign sclk_o     = sclk;
  assign lrclk_o    = lrclk;
  assign sdata_o    = sdata;
  assign underrun_o = underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: reset/startup timing, frame serialisation, underrun,
// backpressure, mid-frame reset (SCLK_DIV_P=4) and the SCLK_DIV_P=1 corner.
module tb_i2s_tx;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [23:0] left_i, right_i;
  logic        ready_o, sclk_o, lrclk_o, sdata_o, underrun_o;

  logic        valid1;
  logic [23:0] left1, right1;
  logic        ready1, sclk1, lrclk1, sdata1, underrun1;

  always #5 clk_i = ~clk_i;

  i2s_tx #(.WIDTH_P(24), .SCLK_DIV_P(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .left_i(left_i), .right_i(right_i),
    .ready_o(ready_o), .sclk_o(sclk_o), .lrclk_o(lrclk_o), .sdata_o(sdata_o), .underrun_o(underrun_o)
  );

  i2s_tx #(.WIDTH_P(24), .SCLK_DIV_P(1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid1), .left_i(left1), .right_i(right1),
    .ready_o(ready1), .sclk_o(sclk1), .lrclk_o(lrclk1), .sdata_o(sdata1), .underrun_o(underrun1)
  );

  typedef struct {
    int k;
    bit valid;
    bit sclk;
    bit ur;
    bit rdy;
    bit lr;
  } rel_vec_t;

  typedef struct {
    bit          feed;
    logic [23:0] l;
    logic [23:0] r;
    int          ur;
    bit          rdy0;
  } frame_vec_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          ur_hi;
    int          extra;
    int          lr_bad;
    int          unstable;
    int          sclk_bad;
    logic        rdy0;
  } frame_obs_t;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  bit feed   = 1'b0;
  int feed_n = 0;

  rel_vec_t   rel_tab[8];
  frame_vec_t frm_tab[7];
  frame_vec_t row;
  frame_obs_t obs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk_i cycle; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    bit acc;
    acc = 1'b0;
    if (feed) begin
      valid_i  = 1'b1;
      left_i   = 24'h800001 + 24'(feed_n);
      right_i  = 24'h7FFFFE - 24'(feed_n);
      acc      = ready_o;
    end
    @(posedge clk_i);
    #1;
    k++;
    if (acc) begin
      chk($sformatf("ready_fall_after_accept%0d", feed_n), 32'(ready_o), 32'd0);
      feed_n++;
    end
  endtask

  function automatic logic o_sd(input bit sel);
    return sel ? sdata1 : sdata_o;
  endfunction
  function automatic logic o_lr(input bit sel);
    return sel ? lrclk1 : lrclk_o;
  endfunction
  function automatic logic o_sclk(input bit sel);
    return sel ? sclk1 : sclk_o;
  endfunction
  function automatic logic o_ur(input bit sel);
    return sel ? underrun1 : underrun_o;
  endfunction

  // Starts just after a boundary edge, walks one 64-slot frame, ends just after the next boundary.
  task automatic capture_frame(input int d, input bit sel, output frame_obs_t o);
    logic b, lr;
    o = '{l: 24'h0, r: 24'h0, ur_hi: 0, extra: 0, lr_bad: 0, unstable: 0, sclk_bad: 0,
          rdy0: (sel ? ready1 : ready_o)};
    for (int s = 0; s < 64; s++) begin
      b  = o_sd(sel);
      lr = o_lr(sel);
      if (lr !== (s >= 32)) o.lr_bad++;
      if (o_sclk(sel) !== 1'b0) o.sclk_bad++;
      if (s >= 1 && s <= 24) o.l = {o.l[22:0], b};
      else if (s >= 33 && s <= 56) o.r = {o.r[22:0], b};
      else if (b !== 1'b0) o.extra++;
      if (s == 0 && o_ur(sel) === 1'b1) o.ur_hi++;
      for (int j = 1; j <= 2 * d; j++) begin
        step();
        if (j < 2 * d) begin
          if (o_sd(sel) !== b || o_lr(sel) !== lr) o.unstable++;
          if (o_sclk(sel) !== ((j >= d) ? 1'b1 : 1'b0)) o.sclk_bad++;
        end
        if ((j < 2 * d || s < 63) && o_ur(sel) === 1'b1) o.ur_hi++;
      end
    end
  endtask

  task automatic check_frame(input string name, input frame_obs_t o, input frame_vec_t v);
    chk({name, "_left"},     32'(o.l),        32'(v.l));
    chk({name, "_right"},    32'(o.r),        32'(v.r));
    chk({name, "_underrun"}, 32'(o.ur_hi),    32'(v.ur));
    chk({name, "_ready0"},   32'(o.rdy0),     32'(v.rdy0));
    chk({name, "_padbits"},  32'(o.extra),    32'd0);
    chk({name, "_lrclk"},    32'(o.lr_bad),   32'd0);
    chk({name, "_hold"},     32'(o.unstable), 32'd0);
    chk({name, "_sclk"},     32'(o.sclk_bad), 32'd0);
  endtask

  initial begin
    //             k  valid sclk ur rdy lr
    rel_tab[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rel_tab[1] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rel_tab[2] = '{3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rel_tab[3] = '{4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rel_tab[4] = '{5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rel_tab[5] = '{6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rel_tab[6] = '{7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rel_tab[7] = '{8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    //             feed  left        right       ur rdy0
    frm_tab[0] = '{1'b0, 24'h000000, 24'h000000, 1, 1'b0};
    frm_tab[1] = '{1'b0, 24'hABCDEF, 24'h123456, 0, 1'b1};
    frm_tab[2] = '{1'b1, 24'h000000, 24'h000000, 1, 1'b1};
    frm_tab[3] = '{1'b1, 24'h800001, 24'h7FFFFE, 0, 1'b1};
    frm_tab[4] = '{1'b1, 24'h800002, 24'h7FFFFD, 0, 1'b1};
    frm_tab[5] = '{1'b0, 24'h800003, 24'h7FFFFC, 0, 1'b1};
    frm_tab[6] = '{1'b0, 24'h000000, 24'h000000, 1, 1'b1};

    reset_i = 1'b0;
    valid_i = 1'b0;
    left_i  = 24'h0;
    right_i = 24'h0;
    valid1  = 1'b0;
    left1   = 24'h0;
    right1  = 24'h0;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_sclk",     32'(sclk_o),     32'd0);
    chk("rst_lrclk",    32'(lrclk_o),    32'd0);
    chk("rst_sdata",    32'(sdata_o),    32'd0);
    chk("rst_underrun", 32'(underrun_o), 32'd0);
    chk("rst_ready",    32'(ready_o),    32'd1);

    // Release; a pair offered on the first boundary edge must wait for the next frame.
    reset_i = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      valid_i = rel_tab[i].valid;
      left_i  = 24'hABCDEF;
      right_i = 24'h123456;
      step();
      chk($sformatf("rel_k%0d_count", rel_tab[i].k), 32'(k),          32'(rel_tab[i].k));
      chk($sformatf("rel_k%0d_sclk",  rel_tab[i].k), 32'(sclk_o),     32'(rel_tab[i].sclk));
      chk($sformatf("rel_k%0d_ur",    rel_tab[i].k), 32'(underrun_o), 32'(rel_tab[i].ur));
      chk($sformatf("rel_k%0d_ready", rel_tab[i].k), 32'(ready_o),    32'(rel_tab[i].rdy));
      chk($sformatf("rel_k%0d_lrclk", rel_tab[i].k), 32'(lrclk_o),    32'(rel_tab[i].lr));
    end
    valid_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      row  = frm_tab[i];
      feed = row.feed;
      if (!feed) valid_i = 1'b0;
      capture_frame(4, 1'b0, obs);
      check_frame($sformatf("frame%0d", i), obs, row);
    end
    feed    = 1'b0;
    valid_i = 1'b0;

    // Frame 7 is mute; load a pair for frame 8, then hold a second one when reset hits.
    valid_i = 1'b1;
    left_i  = 24'hFFFFFF;
    right_i = 24'hFFFFFF;
    step();
    valid_i = 1'b0;
    chk("push_a_ready", 32'(ready_o), 32'd0);
    repeat (511) step();
    chk("f8_underrun", 32'(underrun_o), 32'd0);
    chk("f8_ready",    32'(ready_o),    32'd1);
    valid_i = 1'b1;
    left_i  = 24'h000001;
    right_i = 24'h000001;
    step();
    valid_i = 1'b0;
    chk("push_b_ready", 32'(ready_o), 32'd0);
    repeat (83) step();
    chk("slot10_sclk",  32'(sclk_o),  32'd1);
    chk("slot10_sdata", 32'(sdata_o), 32'd1);

    #2;
    reset_i = 1'b0;
    #1;
    chk("midrst_sclk",     32'(sclk_o),     32'd0);
    chk("midrst_lrclk",    32'(lrclk_o),    32'd0);
    chk("midrst_sdata",    32'(sdata_o),    32'd0);
    chk("midrst_underrun", 32'(underrun_o), 32'd0);
    chk("midrst_ready",    32'(ready_o),    32'd1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("midrst_hold_sclk",  32'(sclk_o),  32'd0);
    chk("midrst_hold_ready", 32'(ready_o), 32'd1);
    reset_i = 1'b1;
    k = 0;
    repeat (8) step();
    chk("postrst_ur_k8", 32'(underrun_o), 32'd1);
    row = '{1'b0, 24'h000000, 24'h000000, 1, 1'b1};
    capture_frame(4, 1'b0, obs);
    check_frame("postrst_frame0", obs, row);
    capture_frame(4, 1'b0, obs);
    check_frame("postrst_frame1", obs, row);

    // SCLK_DIV_P = 1 instance.
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("div1_rst_sclk",  32'(sclk1),  32'd0);
    chk("div1_rst_ready", 32'(ready1), 32'd1);
    reset_i = 1'b1;
    k = 0;
    step();
    chk("div1_k1_sclk", 32'(sclk1), 32'd1);
    valid1 = 1'b1;
    left1  = 24'h5A5A5A;
    right1 = 24'hC3C3C3;
    step();
    valid1 = 1'b0;
    chk("div1_k2_sclk",  32'(sclk1),     32'd0);
    chk("div1_k2_ur",    32'(underrun1), 32'd1);
    chk("div1_k2_ready", 32'(ready1),    32'd0);
    row = '{1'b0, 24'h000000, 24'h000000, 1, 1'b0};
    capture_frame(1, 1'b1, obs);
    check_frame("div1_frame0", obs, row);
    row = '{1'b0, 24'h5A5A5A, 24'hC3C3C3, 0, 1'b1};
    capture_frame(1, 1'b1, obs);
    check_frame("div1_frame1", obs, row);
    row = '{1'b0, 24'h000000, 24'h000000, 1, 1'b1};
    capture_frame(1, 1'b1, obs);
    check_frame("div1_frame2", obs, row);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
